// File: rtl/output_stage_arbiter.sv
// Output stage arbiter: a TDM slot table reserves cycles for guaranteed-service ports.
// Any slot that GS traffic does not consume goes to one best-effort flit, chosen round-robin and packet-locked.
module output_stage_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int PORTS      = 4,
  parameter int SLOTS      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*FLIT_WIDTH-1:0]   in_flit,
  input  logic [PORTS-1:0]              in_valid,
  input  logic [PORTS-1:0]              in_last,
  input  logic [PORTS-1:0]              in_gs,
  output logic [PORTS-1:0]              in_ready,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic [2:0]                    out_flags,
  input  logic                          cfg_we,
  input  logic [$clog2(SLOTS)-1:0]      cfg_slot,
  input  logic                          cfg_en,
  input  logic [$clog2(PORTS)-1:0]      cfg_port,
  output logic [$clog2(SLOTS)-1:0]      cur_slot
);

  // state     | meaning
  // ST_OPEN   | BE arbitration free, round-robin from r_rr_ptr
  // ST_LOCKED | BE held by r_lock_port until its last flit is granted
  localparam int SW = $clog2(SLOTS);
  localparam int PW = $clog2(PORTS);

  typedef enum logic {ST_OPEN, ST_LOCKED} be_state_t;

  be_state_t             r_state, w_state_nxt;
  logic [SW-1:0]         r_slot;
  logic [SLOTS-1:0]      r_tbl_en;
  logic [PW-1:0]         r_tbl_port [SLOTS];
  logic [PW-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]         r_lock_port, w_lock_port_nxt;
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic [2:0]            r_out_flags;

  logic                  w_res_en;
  logic [PW-1:0]         w_res_port;
  logic                  w_gs_hit;
  logic [PORTS-1:0]      w_be_elig;
  logic                  w_be_found;
  logic [PW-1:0]         w_be_port;
  logic                  w_grant, w_grant_gs, w_grant_last;
  logic [PW-1:0]         w_grant_port;
  logic [FLIT_WIDTH-1:0] w_grant_flit;
  logic [PW:0]           w_idx;

  assign w_res_en   = r_tbl_en[r_slot];
  assign w_res_port = r_tbl_port[r_slot];

  always_comb begin
    w_gs_hit = 1'b0;
    for (int p = 0; p < PORTS; p++)
      if (w_res_en && (w_res_port == PW'(p)) && in_valid[p] && in_gs[p]) w_gs_hit = 1'b1;
  end

  // Descending search so the candidate closest above the pointer wins last.
  always_comb begin
    w_be_elig = in_valid & ~in_gs;
    if (r_state == ST_LOCKED) w_be_elig = w_be_elig & (PORTS'(1) << r_lock_port);
    w_be_found = 1'b0;
    w_be_port  = '0;
    w_idx      = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(PORTS)) w_idx = w_idx - (PW+1)'(PORTS);
      if (w_be_elig[w_idx[PW-1:0]]) begin
        w_be_found = 1'b1;
        w_be_port  = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_grant      = 1'b0;
    w_grant_gs   = 1'b0;
    w_grant_port = '0;
    in_ready     = '0;
    if (rst) begin
      if (w_gs_hit) begin
        w_grant      = 1'b1;
        w_grant_gs   = 1'b1;
        w_grant_port = w_res_port;
      end else if (w_be_found) begin
        w_grant      = 1'b1;
        w_grant_port = w_be_port;
      end
    end
    if (w_grant) in_ready = PORTS'(1) << w_grant_port;
  end

  always_comb begin
    w_grant_flit = '0;
    w_grant_last = 1'b0;
    for (int p = 0; p < PORTS; p++)
      if (w_grant_port == PW'(p)) begin
        w_grant_flit = in_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
        w_grant_last = in_last[p];
      end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lock_port_nxt = r_lock_port;
    w_rr_ptr_nxt    = r_rr_ptr;
    if (w_grant && !w_grant_gs) begin
      if (w_grant_last) begin
        w_state_nxt  = ST_OPEN;
        w_rr_ptr_nxt = (w_grant_port == PW'(PORTS - 1)) ? '0 : w_grant_port + 1'b1;
      end else begin
        w_state_nxt     = ST_LOCKED;
        w_lock_port_nxt = w_grant_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot      <= '0;
      r_tbl_en    <= '0;
      for (int s = 0; s < SLOTS; s++) r_tbl_port[s] <= '0;
      r_rr_ptr    <= '0;
      r_lock_port <= '0;
      r_state     <= ST_OPEN;
      r_out_flit  <= '0;
      r_out_flags <= '0;
    end else begin
      r_slot      <= r_slot + 1'b1;
      if (cfg_we) begin
        r_tbl_en[cfg_slot]   <= cfg_en;
        r_tbl_port[cfg_slot] <= cfg_port;
      end
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_lock_port <= w_lock_port_nxt;
      r_state     <= w_state_nxt;
      if (w_grant) begin
        r_out_flit  <= w_grant_flit;
        r_out_flags <= {w_grant_gs, w_grant_last, 1'b1};
      end else begin
        r_out_flags <= '0;
      end
    end
  end

  assign out_flit  = r_out_flit;
  assign out_flags = r_out_flags;
  assign cur_slot  = r_slot;

endmodule

// File: doc/output_stage_arbiter.md
OUTPUT_STAGE_ARBITER -- requirements
Module: output_stage_arbiter

Interface
REQ-001 Parameter FLIT_WIDTH, default 32, SHALL set the flit width in bits.
REQ-002 Parameter PORTS, default 4, SHALL set the number of requesting input ports; legal range 2..8.
REQ-003 Parameter SLOTS, default 8, SHALL set the TDM slot-table depth; legal range 2..64, power of two.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-low reset.
REQ-006 in_flit  input  PORTS*FLIT_WIDTH  SHALL carry per-port flits; port p occupies bits [p*FLIT_WIDTH +: FLIT_WIDTH].
REQ-007 in_valid  input  PORTS  SHALL flag a flit present on each port.
REQ-008 in_last  input  PORTS  SHALL flag the last flit of a packet.
REQ-009 in_gs  input  PORTS  SHALL mark a flit as guaranteed-service (1) or best-effort (0).
REQ-010 in_ready  output  PORTS  SHALL be the combinational one-hot-or-zero grant; the flit is consumed when in_valid & in_ready.
REQ-011 out_flit  output  FLIT_WIDTH  SHALL be the registered forwarded flit.
REQ-012 out_flags  output  3  SHALL be registered {gs, last, valid}, bit 0 = valid.
REQ-013 cfg_we  input  1  SHALL write one slot-table entry.
REQ-014 cfg_slot  input  clog2(SLOTS)  SHALL select the entry written.
REQ-015 cfg_en  input  1  SHALL mark the written slot as reserved (1) or free (0).
REQ-016 cfg_port  input  clog2(PORTS)  SHALL give the owning port of a reserved slot.
REQ-017 cur_slot  output  clog2(SLOTS)  SHALL expose the current slot counter.

Function
REQ-018 The slot counter SHALL increment by 1 every cycle and wrap from SLOTS-1 to 0; it runs regardless of traffic.
REQ-019 In a reserved slot whose owner o has in_valid[o] & in_gs[o], the block SHALL grant o alone and forward with gs=1.
REQ-020 A GS flit (in_gs=1) SHALL never be granted outside a slot reserved for its port.
REQ-021 Any slot not consumed by GS per REQ-019 SHALL be available for one BE flit (in_gs=0).
REQ-022 The BE winner SHALL be chosen round-robin among valid BE ports, starting at the RR pointer and searching upward modulo PORTS.
REQ-023 A granted BE flit with in_last=0 SHALL lock BE arbitration to that port until its in_last=1 flit is granted.
REQ-024 While locked, only the locked port SHALL be BE-eligible; the lock SHALL persist across GS-consumed slots.
REQ-025 On a granted BE flit with in_last=1 from port p, the lock SHALL clear and the RR pointer SHALL become (p+1) mod PORTS.
REQ-026 At most one in_ready bit SHALL be high per cycle; in_ready[p] SHALL be 0 whenever in_valid[p]=0.
REQ-027 The granted flit SHALL appear on out_flit/out_flags exactly 1 cycle after the grant; with no grant, out valid=0, gs=0, last=0 and out_flit holds its previous value.
REQ-028 A cfg_we write SHALL take effect from the next cycle; a write to the current slot SHALL not affect that cycle's arbitration.
REQ-029 Slot-table changes SHALL not clear an active BE lock.

Reset
REQ-030 While rst=0: slot counter=0, all table entries free, RR pointer=0, lock cleared, out_flit=0, out_flags=0, in_ready=0, cfg_we ignored.
REQ-031 Reset asserted mid-packet SHALL drop the lock; after release, arbitration SHALL restart from pointer 0.

Verification
REQ-032 Reset, no config, ports 0..3 valid BE single-flit packets each cycle -> grants 0,1,2,3,0 on consecutive cycles; each out valid one cycle later with gs=0.
REQ-033 Slot 2 reserved for port 1, port 1 always valid GS, port 0 valid BE -> port 1 granted only when cur_slot=2 (every 8 cycles, gs=1); port 0 granted in all other slots.
REQ-034 Slot 3 reserved for port 2, port 2 idle, port 3 valid BE -> port 3 granted in slot 3.
REQ-035 Port 0 sends 4-flit BE packet, port 1 GS owns slot 1 and starts at slot 0 -> port 0 flits at slots 0,2,3,4, port 1 at slot 1; port 2 BE blocked until port 0 last flit, then granted.
REQ-036 cfg_we to current slot 5 (port 3 reserved) while port 3 GS valid -> no port-3 grant at that slot 5; granted at the next slot 5, 8 cycles later.
REQ-037 rst=0 during locked BE packet on port 2 -> out_flags=0 the following cycle; after release port 0 BE request wins first.
